// File: rtl/ef_uart_pkg.sv
// Shared definitions for the EF UART engines: parity modes, receiver state
// encoding, debug view and the expected-parity helper.
package ef_uart_pkg;

  localparam logic [2:0] PAR_NONE   = 3'd0;
  localparam logic [2:0] PAR_ODD    = 3'd1;
  localparam logic [2:0] PAR_EVEN   = 3'd2;
  localparam logic [2:0] PAR_STICK0 = 3'd3;
  localparam logic [2:0] PAR_STICK1 = 3'd4;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  typedef struct packed {
    rx_state_t  state;
    logic       sample_pt;
    logic [3:0] bit_cnt;
  } rx_dbg_t;

  function automatic logic parity_enabled(input logic [2:0] mode);
    return (mode >= PAR_ODD) && (mode <= PAR_STICK1);
  endfunction

  // Only the low dsize bits take part; undefined modes behave like no parity.
  function automatic logic expected_parity(input logic [15:0] data,
                                           input logic [3:0]  dsize,
                                           input logic [2:0]  mode);
    logic x;
    x = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i < int'(dsize)) x = x ^ data[i];
    end
    case (mode)
      PAR_ODD:    return ~x;
      PAR_EVEN:   return x;
      PAR_STICK1: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ef_uart_rx_core_if.sv
// Receive-side character stream plus one-cycle status pulses.
interface ef_uart_rx_core_if #(parameter int MDW = 9);
  // A character moves on every clock edge where rx_valid and rx_ready are both
  // high; rx_data is held stable while rx_valid is high and not yet accepted.
  logic [MDW-1:0] rx_data;
  logic           rx_valid;
  logic           rx_ready;
  logic           frame_err;
  logic           parity_err;
  logic           break_det;
  logic           overrun;
  logic           to_pulse;

  modport master (output rx_data, rx_valid, frame_err, parity_err, break_det,
                         overrun, to_pulse,
                  input  rx_ready);
  modport slave  (input  rx_data, rx_valid, frame_err, parity_err, break_det,
                         overrun, to_pulse,
                  output rx_ready);
endinterface

// File: rtl/ef_uart_baud_gen.sv
// Prescaler down-counter: tick every prescale+1 clocks while enabled.
module ef_uart_baud_gen #(
  parameter int PW = 16
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          en,
  input  logic [PW-1:0] prescale,
  output logic          tick
);

  logic [PW-1:0] cnt_q;

  always_ff @(posedge PCLK) begin
    if (PRESET || !en)       cnt_q <= '0;
    else if (cnt_q == '0)    cnt_q <= prescale;
    else                     cnt_q <= cnt_q - 1'b1;
  end

  assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/ef_uart_rx_core.sv
// UART receive engine: synchroniser, majority filter, framing FSM,
// valid/ready output register and idle-timeout detector.
module ef_uart_rx_core
  import ef_uart_pkg::*;
#(
  parameter int MDW = 9,
  parameter int OS  = 16,
  parameter int PW  = 16,
  parameter int TW  = 6
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          en,
  input  logic          rx,
  input  logic [PW-1:0] prescale,
  input  logic [3:0]    data_size,
  input  logic [2:0]    parity_mode,
  input  logic          stop2,
  input  logic [TW-1:0] timeout_bits,
  ef_uart_rx_core_if.master rx_bus,
  output rx_dbg_t       dbg
);

  localparam int            SW  = $clog2(OS);
  localparam logic [SW-1:0] MID = SW'(OS / 2 - 1);

  logic tick;
  ef_uart_baud_gen #(.PW(PW)) u_baud (
    .PCLK(PCLK), .PRESET(PRESET), .en(en), .prescale(prescale), .tick(tick)
  );

  logic [1:0]     sync_q;
  logic [2:0]     samp_q;
  logic           filt, filt_d_q;
  rx_state_t      state_q, state_d;
  logic [SW-1:0]  s_q;
  logic [3:0]     bcnt_q, dsize;
  logic [MDW-1:0] shreg_q, data_q;
  logic           any_high_q, stop_low_q, sb_q, par_bit_q;
  logic           sample_pt, start_edge, done, par_en;
  logic           frame_now, parity_now, break_now, load, drop;
  logic           valid_q, fe_q, pe_q, brk_q, ovr_q, to_q;
  logic           armed_q;
  logic [TW-1:0]  tcnt_q;

  always_ff @(posedge PCLK) begin
    if (PRESET) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx};
  end

  assign filt = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

  always_comb begin
    if (data_size < 4'd5)         dsize = 4'd5;
    else if (data_size > 4'(MDW)) dsize = 4'(MDW);
    else                          dsize = data_size;
  end

  assign par_en     = parity_enabled(parity_mode);
  assign sample_pt  = tick && (s_q == MID);
  assign start_edge = tick && filt_d_q && !filt;

  always_ff @(posedge PCLK) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE:   if (start_edge) state_d = START;
      START:  if (sample_pt) state_d = filt ? IDLE : DATA;
      DATA:   if (sample_pt && bcnt_q == dsize - 4'd1) state_d = par_en ? PARITY : STOP;
      PARITY: if (sample_pt) state_d = STOP;
      STOP:   if (sample_pt && (!stop2 || sb_q)) begin
                state_d = IDLE;
                done    = 1'b1;
              end
      default: state_d = IDLE;
    endcase
    if (!en) begin
      state_d = IDLE;
      done    = 1'b0;
    end
  end

  // s free-runs in every state so idle bit times stay aligned to the last sample point.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      samp_q     <= 3'b111;
      filt_d_q   <= 1'b1;
      s_q        <= '0;
      bcnt_q     <= '0;
      shreg_q    <= '0;
      any_high_q <= 1'b0;
      stop_low_q <= 1'b0;
      sb_q       <= 1'b0;
      par_bit_q  <= 1'b0;
    end else if (!en) begin
      s_q <= '0;
    end else if (tick) begin
      samp_q   <= {samp_q[1:0], sync_q[1]};
      filt_d_q <= filt;
      s_q      <= (state_q == IDLE && start_edge) ? '0 : s_q + 1'b1;
      case (state_q)
        IDLE: if (start_edge) begin
          bcnt_q     <= '0;
          shreg_q    <= '0;
          any_high_q <= 1'b0;
          stop_low_q <= 1'b0;
          sb_q       <= 1'b0;
        end
        DATA: if (sample_pt) begin
          shreg_q[bcnt_q] <= filt;
          any_high_q      <= any_high_q | filt;
          bcnt_q          <= bcnt_q + 4'd1;
        end
        PARITY: if (sample_pt) begin
          par_bit_q  <= filt;
          any_high_q <= any_high_q | filt;
        end
        STOP: if (sample_pt) begin
          stop_low_q <= stop_low_q | !filt;
          any_high_q <= any_high_q | filt;
          sb_q       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign frame_now  = stop_low_q || !filt;
  assign break_now  = !any_high_q && !filt;
  assign parity_now = par_en && (par_bit_q != expected_parity(16'(shreg_q), dsize, parity_mode));
  assign load       = done && !break_now && !(valid_q && !rx_bus.rx_ready);
  assign drop       = done && !break_now && valid_q && !rx_bus.rx_ready;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      brk_q   <= 1'b0;
      ovr_q   <= 1'b0;
      to_q    <= 1'b0;
      armed_q <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      fe_q  <= done && frame_now;
      pe_q  <= done && parity_now;
      brk_q <= done && break_now;
      ovr_q <= drop;
      to_q  <= 1'b0;
      if (load) begin
        data_q  <= shreg_q;
        valid_q <= 1'b1;
      end else if (valid_q && rx_bus.rx_ready) begin
        valid_q <= 1'b0;
      end
      if (done) begin
        armed_q <= 1'b1;
        tcnt_q  <= '0;
      end else if (state_q == IDLE && start_edge) begin
        armed_q <= 1'b0;
        tcnt_q  <= '0;
      end else if (armed_q && sample_pt && state_q == IDLE && filt && timeout_bits != '0) begin
        tcnt_q <= tcnt_q + 1'b1;
        if (tcnt_q + 1'b1 == timeout_bits) begin
          to_q    <= 1'b1;
          armed_q <= 1'b0;
        end
      end
    end
  end

  assign rx_bus.rx_data    = data_q;
  assign rx_bus.rx_valid   = valid_q;
  assign rx_bus.frame_err  = fe_q;
  assign rx_bus.parity_err = pe_q;
  assign rx_bus.break_det  = brk_q;
  assign rx_bus.overrun    = ovr_q;
  assign rx_bus.to_pulse   = to_q;

  always_comb begin
    dbg.state     = state_q;
    dbg.sample_pt = sample_pt;
    dbg.bit_cnt   = bcnt_q;
  end

endmodule

// File: tb/tb_ef_uart_rx_core.sv
// Directed bench for ef_uart_rx_core at prescale=2, OS=16 (48 PCLK per bit).
module tb_ef_uart_rx_core;
  import ef_uart_pkg::*;

  localparam int BIT = 48;

  logic       PCLK;
  logic       PRESET;
  logic       en;
  logic       rx;
  logic [15:0] prescale;
  logic [3:0] data_size;
  logic [2:0] parity_mode;
  logic       stop2;
  logic [5:0] timeout_bits;
  rx_dbg_t    dbg;

  ef_uart_rx_core_if #(.MDW(9)) bus ();

  ef_uart_rx_core #(.MDW(9), .OS(16), .PW(16), .TW(6)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .en(en), .rx(rx), .prescale(prescale),
    .data_size(data_size), .parity_mode(parity_mode), .stop2(stop2),
    .timeout_bits(timeout_bits), .rx_bus(bus), .dbg(dbg)
  );

  // clock / reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int cyc = 0, n_vrise = 0, t_vrise = 0;
  int n_fe = 0, n_pe = 0, n_brk = 0, n_ovr = 0, n_to = 0;
  int t_fe = 0, t_brk = 0, t_to = 0;
  logic prev_valid = 1'b0;

  always @(negedge PCLK) begin
    cyc = cyc + 1;
    if (bus.rx_valid && !prev_valid) begin n_vrise = n_vrise + 1; t_vrise = cyc; end
    prev_valid = bus.rx_valid;
    if (bus.rx_valid && bus.rx_ready) got_q.push_back(bus.rx_data);
    if (bus.frame_err)  begin n_fe = n_fe + 1; t_fe = cyc; end
    if (bus.parity_err) n_pe = n_pe + 1;
    if (bus.break_det)  begin n_brk = n_brk + 1; t_brk = cyc; end
    if (bus.overrun)    n_ovr = n_ovr + 1;
    if (bus.to_pulse)   begin n_to = n_to + 1; t_to = cyc; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [8:0] exp);
    logic [31:0] v;
    v = 32'hDEAD_BEEF;
    if (got_q.size() > 0) v = 32'(got_q.pop_front());
    chk(tag, v, 32'(exp));
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic send_frame(input logic [8:0] d, input int nbits, input int pbit, input logic stop_v);
    rx = 1'b0; step(BIT);
    for (int i = 0; i < nbits; i++) begin
      rx = d[i]; step(BIT);
    end
    if (pbit >= 0) begin
      rx = pbit[0]; step(BIT);
    end
    rx = stop_v; step(BIT);
    rx = 1'b1;
  endtask

  int fe0, pe0, brk0, ovr0, v0, to0, t_first;
  logic [8:0] ch;
  logic hit;

  initial begin
    PRESET = 1'b1; en = 1'b1; rx = 1'b1; prescale = 16'd2; data_size = 4'd8;
    parity_mode = PAR_NONE; stop2 = 1'b0; timeout_bits = 6'd0; bus.rx_ready = 1'b1;
    step(4);
    chk("reset_status", {26'd0, bus.rx_valid, bus.frame_err, bus.parity_err,
                         bus.break_det, bus.overrun, bus.to_pulse}, 32'd0);
    chk("reset_data", 32'(bus.rx_data), 32'd0);
    chk("reset_state", 32'(dbg.state), 32'(IDLE));
    PRESET = 1'b0;
    step(2 * BIT);

    // 1: eight back-to-back 8N1 characters
    fe0 = n_fe; pe0 = n_pe; brk0 = n_brk; ovr0 = n_ovr; v0 = n_vrise;
    t_first = 0;
    for (int i = 1; i <= 8; i++) begin
      ch = 9'(i * 17);
      exp_q.push_back(ch);
      send_frame(ch, 8, -1, 1'b1);
      if (i == 1) t_first = t_vrise;
    end
    step(2 * BIT);
    chk("t1_valid_count", 32'(n_vrise - v0), 32'd8);
    chk("t1_got_count", 32'(got_q.size()), 32'd8);
    while (exp_q.size() > 0) pop_chk("t1_data", exp_q.pop_front());
    chk("t1_no_flags", 32'((n_fe - fe0) + (n_pe - pe0) + (n_brk - brk0) + (n_ovr - ovr0)), 32'd0);
    chk("t1_char_spacing", 32'(t_vrise - t_first), 32'(7 * 10 * BIT));

    // 2: 7-bit parity; 0x55 has four ones, even parity bit is 0, odd is 1
    data_size = 4'd7; parity_mode = PAR_EVEN;
    pe0 = n_pe; fe0 = n_fe;
    send_frame(9'h055, 7, 1, 1'b1);
    step(2 * BIT);
    chk("t2_even_bad_perr", 32'(n_pe - pe0), 32'd1);
    pop_chk("t2_even_bad_data", 9'h055);
    parity_mode = PAR_ODD;
    send_frame(9'h055, 7, 1, 1'b1);
    step(2 * BIT);
    chk("t2_odd_good_perr", 32'(n_pe - pe0), 32'd1);
    pop_chk("t2_odd_good_data", 9'h055);
    chk("t2_no_frame", 32'(n_fe - fe0), 32'd0);
    data_size = 4'd8; parity_mode = PAR_NONE;

    // 3: glitch rejection
    v0 = n_vrise;
    rx = 1'b0; step(3); rx = 1'b1; step(2 * BIT);
    chk("t3_glitch_state", 32'(dbg.state), 32'(IDLE));
    rx = 1'b0; step(19); rx = 1'b1; step(2 * BIT);
    chk("t3_short_state", 32'(dbg.state), 32'(IDLE));
    chk("t3_no_valid", {31'd0, bus.rx_valid}, 32'd0);
    chk("t3_no_rise", 32'(n_vrise - v0), 32'd0);

    // 4: break and framing error
    fe0 = n_fe; brk0 = n_brk;
    rx = 1'b0; step(12 * BIT); rx = 1'b1; step(2 * BIT);
    chk("t4_break", 32'(n_brk - brk0), 32'd1);
    chk("t4_break_frame", 32'(n_fe - fe0), 32'd1);
    chk("t4_same_cycle", 32'(t_brk - t_fe), 32'd0);
    chk("t4_break_no_data", 32'(n_vrise - v0), 32'd0);
    send_frame(9'h0A5, 8, -1, 1'b0);
    step(2 * BIT);
    chk("t4_frame_err", 32'(n_fe - fe0), 32'd2);
    chk("t4_no_break", 32'(n_brk - brk0), 32'd1);
    pop_chk("t4_frame_data", 9'h0A5);

    // 5: overrun, then completion coinciding with acceptance
    bus.rx_ready = 1'b0;
    ovr0 = n_ovr;
    send_frame(9'h012, 8, -1, 1'b1); step(2 * BIT);
    send_frame(9'h034, 8, -1, 1'b1); step(2 * BIT);
    chk("t5_overrun", 32'(n_ovr - ovr0), 32'd1);
    chk("t5_held_data", 32'(bus.rx_data), 32'h12);
    bus.rx_ready = 1'b1; step(1); bus.rx_ready = 1'b0;
    pop_chk("t5_first_accept", 9'h012);
    send_frame(9'h056, 8, -1, 1'b1); step(2 * BIT);
    hit = 1'b0;
    fork
      send_frame(9'h078, 8, -1, 1'b1);
      begin
        for (int k = 0; k < 12 * BIT; k++) begin
          @(posedge PCLK); #1;
          if (dbg.state == STOP && dbg.sample_pt) begin
            bus.rx_ready = 1'b1; hit = 1'b1;
            @(posedge PCLK); #1;
            bus.rx_ready = 1'b0;
            break;
          end
        end
      end
    join
    step(2 * BIT);
    chk("t5_completion_seen", {31'd0, hit}, 32'd1);
    chk("t5_same_cycle_no_ovr", 32'(n_ovr - ovr0), 32'd1);
    pop_chk("t5_same_cycle_old", 9'h056);
    chk("t5_same_cycle_new", 32'(bus.rx_data), 32'h78);
    chk("t5_same_cycle_valid", {31'd0, bus.rx_valid}, 32'd1);
    bus.rx_ready = 1'b1; step(1);
    pop_chk("t5_second_accept", 9'h078);

    // 6: idle timeout, then enable drop and reset mid-character
    timeout_bits = 6'd4; to0 = n_to;
    send_frame(9'h03C, 8, -1, 1'b1);
    step(8 * BIT);
    pop_chk("t6_data", 9'h03C);
    chk("t6_to_once", 32'(n_to - to0), 32'd1);
    chk("t6_to_delay", 32'(t_to - t_vrise), 32'(4 * BIT));
    step(10 * BIT);
    chk("t6_to_no_repeat", 32'(n_to - to0), 32'd1);
    timeout_bits = 6'd0;

    bus.rx_ready = 1'b0;
    send_frame(9'h05A, 8, -1, 1'b1); step(2 * BIT);
    v0 = n_vrise; ovr0 = n_ovr;
    fork
      send_frame(9'h0FF, 8, -1, 1'b1);
      begin
        step(4 * BIT);
        en = 1'b0; step(1);
        chk("t6_en_state", 32'(dbg.state), 32'(IDLE));
        chk("t6_en_keep_valid", {31'd0, bus.rx_valid}, 32'd1);
        chk("t6_en_keep_data", 32'(bus.rx_data), 32'h5A);
        en = 1'b1;
      end
    join
    step(2 * BIT);
    chk("t6_en_abort_silent", 32'((n_vrise - v0) + (n_ovr - ovr0)), 32'd0);
    fork
      send_frame(9'h0FF, 8, -1, 1'b1);
      begin
        step(4 * BIT);
        PRESET = 1'b1; step(1);
        chk("t6_rst_status", {26'd0, bus.rx_valid, bus.frame_err, bus.parity_err,
                              bus.break_det, bus.overrun, bus.to_pulse}, 32'd0);
        chk("t6_rst_data", 32'(bus.rx_data), 32'd0);
        chk("t6_rst_state", 32'(dbg.state), 32'(IDLE));
        PRESET = 1'b0;
      end
    join
    step(2 * BIT);
    chk("t6_rst_no_char", {31'd0, bus.rx_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ef_uart_rx_core.md
Name: ef_uart_rx_core

Overview:
- Parametrised UART receive engine; next generation of the receive path inside the EF UART APB peripheral.
- Sits between the synchronised RX pin and the RX FIFO / bus wrapper.
- Adds over the current receiver:
  - data width 5..MDW bits;
  - configurable oversampling;
  - five parity modes, 1/2 stop bits;
  - glitch-filtered start detection;
  - break, framing, parity, overrun and idle-timeout reporting.

Parameters:
- MDW, 9, maximum data bits per character (5..9).
- OS, 16, samples per bit; power of two, 8 or 16.
- PW, 16, prescaler width.
- TW, 6, idle-timeout counter width, in bit times.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  synchronous reset, active-high.
- en  in  1  receiver enable; 0 forces IDLE and clears the tick counters.
- rx  in  1  serial input, asynchronous.
- prescale  in  PW  baud tick every prescale+1 PCLK cycles.
- data_size  in  4  data bits per character (5..MDW); values outside the range are clamped.
- parity_mode  in  3  0 none, 1 odd, 2 even, 3 stick-0, 4 stick-1; others treated as none.
- stop2  in  1  expect two stop bits.
- timeout_bits  in  TW  idle bit-times before to_pulse; 0 disables timeout.
- rx_data  out  MDW  received character, right-aligned, upper bits zero.
- rx_valid  out  1  rx_data holds an unconsumed character.
- rx_ready  in  1  consumer accepts rx_data.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- parity_err  out  1  one-cycle pulse: parity mismatch.
- break_det  out  1  one-cycle pulse: all data bits, parity and stop bit low.
- overrun  out  1  one-cycle pulse: character completed while rx_valid && !rx_ready; new character dropped.
- to_pulse  out  1  one-cycle pulse on idle timeout.

Behaviour:
- Reset values:
  - all outputs 0, including rx_data;
  - FSM in IDLE;
  - synchroniser flops 1.
- Input path: rx passes through a 2-flop synchroniser, then a 3-sample majority filter clocked on sample ticks. Only the filtered value is used.
- Tick generation: down-counter loads prescale and pulses tick on reaching 0. prescale=0 gives a tick every cycle. One bit time = OS ticks.
- FSM, with s = per-bit sample count 0..OS-1 (sampling point is s == OS/2-1):
  - IDLE: filtered rx falling edge → START, s=0.
  - START: at the sampling point, rx=1 → IDLE (false start); rx=0 → DATA.
  - DATA: sample one bit per bit time, LSB first; after data_size bits → PARITY if parity_mode ≠ none, else STOP.
  - PARITY: compare against expected value (odd: XOR of data = !p; even: XOR of data = p; stick-0: p=0; stick-1: p=1).
  - STOP: sample stop bit. If stop2=1, a second stop bit is sampled and frame_err is raised if either is low. Return to IDLE at the sampling point of the last stop bit.
- Completion, at the last stop-bit sample:
  - frame_err, parity_err, break_det pulse in the same cycle. break_det and frame_err may both be 1.
  - Data is still delivered on error, except on break, which delivers nothing.
- Output handshake:
  - rx_valid rises 1 cycle after completion.
  - rx_data is stable while rx_valid=1.
  - rx_valid && rx_ready clears rx_valid on the next edge.
  - Completion in the same cycle as rx_valid && rx_ready loads the new character with no overrun.
- Timeout:
  - Counter counts whole bit times spent in IDLE with filtered rx=1, armed only after a completed character.
  - to_pulse fires when the count equals timeout_bits, then disarms.
  - A new start bit clears and disarms the counter.
- Mid-operation changes:
  - en=0 or PRESET mid-character aborts: no flags, no data.
  - en=0 does not clear rx_valid or rx_data; PRESET does.
- Configuration inputs may change only while in IDLE; behaviour otherwise is undefined.

Decomposition:
- Shared package ef_uart_pkg:
  - parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN, PAR_STICK0, PAR_STICK1);
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP);
  - a function computing expected parity from data, data_size and parity_mode.
- One sub-module, ef_uart_baud_gen: prescaler down-counter plus tick output, reusable by the TX engine.
- Synchroniser, filter, FSM, handshake and timeout live in ef_uart_rx_core.

Test Plan:
1. prescale=2, OS=16, data_size=8, no parity, 1 stop; drive 0x11..0x88 back to back with rx_ready=1 → eight rx_valid pulses with matching rx_data; no error flags; 48 PCLK per bit.
2. data_size=7, even parity, 0x55 sent with a wrong parity bit → rx_data=0x55, rx_valid=1, parity_err pulses once. Odd parity with the correct bit → no error.
3. 1-sample (3 PCLK) low glitch on rx, then a 0.4-bit low pulse → no start accepted; FSM back in IDLE; rx_valid stays 0.
4. rx held low for 12 bit times → break_det=1 and frame_err=1 in the same cycle; no rx_valid. Stop bit forced low for 0xA5 → frame_err, rx_data=0xA5.
5. rx_ready=0; send 0x12 then 0x34 → rx_data stays 0x12, overrun pulses at the second completion; asserting rx_ready in the completion cycle instead yields 0x34 with no overrun.
6. timeout_bits=4 after 0x3C received → to_pulse exactly 4 bit times (192 PCLK at prescale=2) after the stop-bit sample; repeated idle gives no second pulse. PRESET asserted mid-character → all outputs 0 next cycle.
